// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative signed
// multiply (Booth radix-2) and signed divide (restoring), one step per cycle.
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic [4:0]       opcode,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             div_zero,
   output logic             illegal_op
);

   // state | meaning
   // IDLE  | waiting for start; only state that accepts a request
   // CALC  | iterative MUL/DIV, one partial step per cycle for WIDTH cycles
   // DONE  | one-cycle done pulse, results valid; returns to IDLE
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam int CW = $clog2(WIDTH);

   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_SUB = 5'b00100;
   localparam logic [4:0] OP_SHR = 5'b00101;
   localparam logic [4:0] OP_SHL = 5'b00110;
   localparam logic [4:0] OP_ROR = 5'b00111;
   localparam logic [4:0] OP_ROL = 5'b01000;
   localparam logic [4:0] OP_AND = 5'b01001;
   localparam logic [4:0] OP_OR  = 5'b01010;
   localparam logic [4:0] OP_MUL = 5'b01110;
   localparam logic [4:0] OP_DIV = 5'b01111;
   localparam logic [4:0] OP_NEG = 5'b10000;
   localparam logic [4:0] OP_NOT = 5'b10001;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             op_mul_q, op_mul_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic             qm1_q, qm1_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0] res_lo_q, res_lo_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d;
   logic             dz_q, dz_d;
   logic             ill_q, ill_d;

   logic [SHW-1:0]     amt;
   logic [2*WIDTH-1:0] rot_r;
   logic [2*WIDTH-1:0] rot_l;
   logic [WIDTH-1:0]   sgl_lo;
   logic               sgl_ill;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;

   always_comb begin
      amt     = b_in[SHW-1:0];
      rot_r   = {a_in, a_in} >> amt;
      rot_l   = {a_in, a_in} << amt;
      sgl_lo  = '0;
      sgl_ill = 1'b0;
      case (opcode)
         OP_ADD:         sgl_lo = a_in + b_in;
         OP_SUB:         sgl_lo = a_in - b_in;
         OP_SHR:         sgl_lo = a_in >> amt;
         OP_SHL:         sgl_lo = a_in << amt;
         OP_ROR:         sgl_lo = rot_r[WIDTH-1:0];
         OP_ROL:         sgl_lo = rot_l[2*WIDTH-1:WIDTH];
         OP_AND:         sgl_lo = a_in & b_in;
         OP_OR:          sgl_lo = a_in | b_in;
         OP_NEG:         sgl_lo = -b_in;
         OP_NOT:         sgl_lo = ~b_in;
         OP_MUL, OP_DIV: sgl_lo = '0;
         default:        sgl_ill = 1'b1;
      endcase
      // magnitude of the most-negative value is representable as unsigned
      a_abs = a_in[WIDTH-1] ? -a_in : a_in;
      b_abs = b_in[WIDTH-1] ? -b_in : b_in;
   end

   logic [WIDTH:0]   m_ext;
   logic [WIDTH:0]   bsum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   step_acc;
   logic [WIDTH-1:0] step_lo;
   logic             step_qm1;
   logic [WIDTH-1:0] fin_lo;
   logic [WIDTH-1:0] fin_hi;

   always_comb begin
      m_ext  = {m_q[WIDTH-1], m_q};
      case ({lo_q[0], qm1_q})
         2'b01:   bsum = acc_q + m_ext;
         2'b10:   bsum = acc_q - m_ext;
         default: bsum = acc_q;
      endcase
      rem_sh = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, m_q};
      if (op_mul_q) begin
         step_acc = {bsum[WIDTH], bsum[WIDTH:1]};
         step_lo  = {bsum[0], lo_q[WIDTH-1:1]};
         step_qm1 = lo_q[0];
         fin_lo   = step_lo;
         fin_hi   = step_acc[WIDTH-1:0];
      end else begin
         if (!diff[WIDTH]) begin
            step_acc = diff;
            step_lo  = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            step_acc = rem_sh;
            step_lo  = {lo_q[WIDTH-2:0], 1'b0};
         end
         step_qm1 = 1'b0;
         fin_lo   = neg_quo_q ? -step_lo : step_lo;
         fin_hi   = neg_rem_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_mul_d  = op_mul_q;
      acc_d     = acc_q;
      lo_d      = lo_q;
      m_d       = m_q;
      qm1_d     = qm1_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      res_lo_d  = res_lo_q;
      res_hi_d  = res_hi_q;
      dz_d      = dz_q;
      ill_d     = ill_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               dz_d  = 1'b0;
               ill_d = 1'b0;
               if (opcode == OP_MUL) begin
                  acc_d    = '0;
                  lo_d     = b_in;
                  m_d      = a_in;
                  qm1_d    = 1'b0;
                  op_mul_d = 1'b1;
                  cnt_d    = CW'(WIDTH - 1);
                  state_d  = CALC;
               end else if (opcode == OP_DIV) begin
                  if (b_in == '0) begin
                     res_lo_d = '1;
                     res_hi_d = a_in;
                     dz_d     = 1'b1;
                     state_d  = DONE;
                  end else begin
                     acc_d     = '0;
                     lo_d      = a_abs;
                     m_d       = b_abs;
                     qm1_d     = 1'b0;
                     neg_quo_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
                     neg_rem_d = a_in[WIDTH-1];
                     op_mul_d  = 1'b0;
                     cnt_d     = CW'(WIDTH - 1);
                     state_d   = CALC;
                  end
               end else begin
                  res_lo_d = sgl_lo;
                  res_hi_d = '0;
                  ill_d    = sgl_ill;
                  state_d  = DONE;
               end
            end
         end
         CALC: begin
            acc_d = step_acc;
            lo_d  = step_lo;
            qm1_d = step_qm1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               res_lo_d = fin_lo;
               res_hi_d = fin_hi;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_mul_q  <= 1'b0;
         acc_q     <= '0;
         lo_q      <= '0;
         m_q       <= '0;
         qm1_q     <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         res_lo_q  <= '0;
         res_hi_q  <= '0;
         dz_q      <= 1'b0;
         ill_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_mul_q  <= op_mul_d;
         acc_q     <= acc_d;
         lo_q      <= lo_d;
         m_q       <= m_d;
         qm1_q     <= qm1_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         res_lo_q  <= res_lo_d;
         res_hi_q  <= res_hi_d;
         dz_q      <= dz_d;
         ill_q     <= ill_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign result_lo  = res_lo_q;
   assign result_hi  = res_hi_q;
   assign div_zero   = dz_q;
   assign illegal_op = ill_q;

endmodule
